// File: rtl/lc3_mem_responder_if.sv
// Core <-> memory bus for the lc3 instruction and data ports.
interface lc3_mem_responder_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic        I_macc;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        D_macc;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;

  // Core side drives requests, sees completions
  modport master (
    output pc, instrmem_rd, I_macc, D_macc, Data_rd, Data_addr, Data_din,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  // Memory side answers requests
  modport slave (
    input  pc, instrmem_rd, I_macc, D_macc, Data_rd, Data_addr, Data_din,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the lc3 fetch and data ports: one unified word
// array, two independent wait-state FSMs, one-cycle completion strobes.

// One port FSM: IDLE -> (BUSY) -> RESP -> IDLE. 'fire' is high during the
// RESP cycle; the access and the strobe both land on the edge leaving RESP,
// so the data is valid in the same cycle the strobe is high.
module lc3_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              accept,
  output logic              fire,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              complete
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              complete_q, complete_d;

  assign accept   = (state_q == IDLE) && req;
  assign fire     = (state_q == RESP);
  assign acc_addr = addr_q;
  assign complete = complete_q;

  // Next-state: accept, count down wait states, abort when request drops
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    complete_d = (state_q == RESP);
    unique case (state_q)
      IDLE: if (req) begin
        addr_d = addr;
        if (LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered strobe; reset drops any access in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      complete_q <= complete_d;
    end
  end
endmodule

module lc3_mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int I_LATENCY = 1,
  parameter int D_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_mem_responder_if.slave   bus,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [15:0]          load_data
);
  logic [15:0] mem [2**ADDR_W];

  logic              i_fire, d_fire, d_accept, i_accept_unused;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              i_complete, d_complete;

  logic              d_rd_q, d_rd_d;
  logic [15:0]       d_wdata_q, d_wdata_d;
  logic [15:0]       instr_dout_q, instr_dout_d;
  logic [15:0]       data_dout_q, data_dout_d;

  // Upper address bits alias; they are deliberately dropped
  logic addr_hi_unused;
  assign addr_hi_unused = ^{bus.pc, bus.Data_addr};

  lc3_mem_port #(.ADDR_W(ADDR_W), .LATENCY(I_LATENCY)) u_iport (
    .clock    (clock),
    .reset    (reset),
    .req      (bus.I_macc & bus.instrmem_rd),
    .addr     (bus.pc[ADDR_W-1:0]),
    .accept   (i_accept_unused),
    .fire     (i_fire),
    .acc_addr (i_addr),
    .complete (i_complete)
  );

  lc3_mem_port #(.ADDR_W(ADDR_W), .LATENCY(D_LATENCY)) u_dport (
    .clock    (clock),
    .reset    (reset),
    .req      (bus.D_macc),
    .addr     (bus.Data_addr[ADDR_W-1:0]),
    .accept   (d_accept),
    .fire     (d_fire),
    .acc_addr (d_addr),
    .complete (d_complete)
  );

  // Capture direction and store data at accept; later bus changes are ignored.
  // Read data is taken from the array before this edge's writes land.
  always_comb begin
    d_rd_d       = d_rd_q;
    d_wdata_d    = d_wdata_q;
    instr_dout_d = instr_dout_q;
    data_dout_d  = data_dout_q;
    if (d_accept) begin
      d_rd_d    = bus.Data_rd;
      d_wdata_d = bus.Data_din;
    end
    if (i_fire)           instr_dout_d = mem[i_addr];
    if (d_fire && d_rd_q) data_dout_d  = mem[d_addr];
  end

  // Latched data-request state and the held read-data outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_rd_q       <= 1'b0;
      d_wdata_q    <= '0;
      instr_dout_q <= '0;
      data_dout_q  <= '0;
    end else begin
      d_rd_q       <= d_rd_d;
      d_wdata_q    <= d_wdata_d;
      instr_dout_q <= instr_dout_d;
      data_dout_q  <= data_dout_d;
    end
  end

  // Array writes (not reset); the core store is last so it wins a same-word backdoor write
  always_ff @(posedge clock) begin
    if (load_en)           mem[load_addr] <= load_data;
    if (d_fire && !d_rd_q) mem[d_addr]    <= d_wdata_q;
  end

  assign bus.Instr_dout     = instr_dout_q;
  assign bus.complete_instr = i_complete;
  assign bus.Data_dout      = data_dout_q;
  assign bus.complete_data  = d_complete;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder (I_LATENCY=1, D_LATENCY=3).
module tb_lc3_mem_responder;
  localparam int ADDR_W = 8;
  localparam int I_LAT  = 1;
  localparam int D_LAT  = 3;

  logic              clock;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;

  lc3_mem_responder_if bus();

  lc3_mem_responder #(.ADDR_W(ADDR_W), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_load(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Data access with latency measurement; bus is scrambled after accept
  task automatic d_access(input string tag, input logic [15:0] a, input logic [15:0] din,
                          input logic rd, output logic [15:0] dout);
    int n;
    n = 0;
    bus.Data_addr = a; bus.Data_din = din; bus.Data_rd = rd; bus.D_macc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin bus.Data_addr = ~a; bus.Data_din = ~din; bus.Data_rd = ~rd; end
      if (bus.complete_data) begin n = i; break; end
    end
    bus.D_macc = 1'b0;
    chk({tag, "_lat"}, n, D_LAT + 1);
    dout = bus.Data_dout;
    tick();
    chk({tag, "_pulse1"}, {31'd0, bus.complete_data}, 32'd0);
  endtask

  task automatic i_fetch(input string tag, input logic [15:0] a, output logic [15:0] dout);
    int n;
    n = 0;
    bus.pc = a; bus.I_macc = 1'b1; bus.instrmem_rd = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) bus.pc = ~a;
      if (bus.complete_instr) begin n = i; break; end
    end
    bus.I_macc = 1'b0;
    chk({tag, "_lat"}, n, I_LAT + 1);
    dout = bus.Instr_dout;
    tick();
    chk({tag, "_pulse1"}, {31'd0, bus.complete_instr}, 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    logic        seen;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    bus.pc = '0; bus.instrmem_rd = 1'b0; bus.I_macc = 1'b0;
    bus.D_macc = 1'b0; bus.Data_rd = 1'b0; bus.Data_addr = '0; bus.Data_din = '0;
    tick(); tick();
    chk("rst_instr_dout", {16'd0, bus.Instr_dout}, 32'h0);
    chk("rst_data_dout",  {16'd0, bus.Data_dout},  32'h0);
    chk("rst_ci", {31'd0, bus.complete_instr}, 32'd0);
    chk("rst_cd", {31'd0, bus.complete_data},  32'd0);

    // Backdoor preload (memory is not reset)
    bd_load(8'h10, 16'h1234);
    bd_load(8'h30, 16'h1111);
    bd_load(8'h40, 16'h0001);
    bd_load(8'h50, 16'h2222);
    reset = 1'b0;
    tick();

    // Fetch with aliasing, exact strobe timing, back-to-back throughput
    bus.pc = 16'h3010; bus.I_macc = 1'b1; bus.instrmem_rd = 1'b1;
    tick(); chk("f_k_ci",    {31'd0, bus.complete_instr}, 32'd0);
    tick(); chk("f_k1_ci",   {31'd0, bus.complete_instr}, 32'd1);
            chk("f_k1_data", {16'd0, bus.Instr_dout}, 32'h1234);
    tick(); chk("f_k2_ci",   {31'd0, bus.complete_instr}, 32'd0);
    tick(); chk("f_k3_ci",   {31'd0, bus.complete_instr}, 32'd1);
    bus.I_macc = 1'b0;
    tick(); chk("f_k4_ci",   {31'd0, bus.complete_instr}, 32'd0);
    tick(); chk("f_k5_ci",   {31'd0, bus.complete_instr}, 32'd0);
            chk("f_hold",    {16'd0, bus.Instr_dout}, 32'h1234);

    // I_macc without instrmem_rd is not a request
    bus.I_macc = 1'b1; bus.instrmem_rd = 1'b0; seen = 1'b0;
    repeat (4) begin tick(); seen |= bus.complete_instr; end
    chk("f_nord", {31'd0, seen}, 32'd0);
    bus.I_macc = 1'b0;

    // Asynchronous reset mid-cycle clears outputs before the next edge
    #3 reset = 1'b1;
    #1 chk("arst_instr_dout", {16'd0, bus.Instr_dout}, 32'h0);
    tick(); reset = 1'b0; tick();

    // Store then load, D_LATENCY=3; store leaves Data_dout alone
    d_access("st20", 16'h0020, 16'hBEEF, 1'b0, v);
    chk("st20_dout", {16'd0, v}, 32'h0);
    d_access("ld20", 16'h0020, 16'h0000, 1'b1, v);
    chk("ld20_dout", {16'd0, v}, 32'hBEEF);

    // Abort: drop store request during BUSY
    bus.Data_addr = 16'h0030; bus.Data_din = 16'h5555; bus.Data_rd = 1'b0; bus.D_macc = 1'b1;
    tick();
    bus.D_macc = 1'b0; seen = 1'b0;
    repeat (5) begin tick(); seen |= bus.complete_data; end
    chk("abort_strobe", {31'd0, seen}, 32'd0);
    d_access("ld30", 16'h0030, 16'h0000, 1'b1, v);
    chk("ld30_dout", {16'd0, v}, 32'h1111);

    // Collision: I read, D store and backdoor write all hit 0x40 on one edge
    bus.Data_addr = 16'h0040; bus.Data_din = 16'hAAAA; bus.Data_rd = 1'b0; bus.D_macc = 1'b1;
    tick(); tick();
    bus.pc = 16'h0040; bus.I_macc = 1'b1; bus.instrmem_rd = 1'b1;
    tick();
    bus.I_macc = 1'b0;
    load_en = 1'b1; load_addr = 8'h40; load_data = 16'h9999;
    tick();
    load_en = 1'b0; bus.D_macc = 1'b0;
    chk("coll_ci",  {31'd0, bus.complete_instr}, 32'd1);
    chk("coll_cd",  {31'd0, bus.complete_data},  32'd1);
    chk("coll_rbw", {16'd0, bus.Instr_dout}, 32'h0001);
    tick();
    i_fetch("f40", 16'h0040, v);
    chk("f40_dout", {16'd0, v}, 32'hAAAA);

    // D load vs backdoor write to the same word: load sees the old value
    bus.Data_addr = 16'h0020; bus.Data_rd = 1'b1; bus.D_macc = 1'b1;
    tick(); tick(); tick();
    load_en = 1'b1; load_addr = 8'h20; load_data = 16'h4321;
    tick();
    load_en = 1'b0; bus.D_macc = 1'b0;
    chk("ldcoll_cd",   {31'd0, bus.complete_data}, 32'd1);
    chk("ldcoll_dout", {16'd0, bus.Data_dout}, 32'hBEEF);
    tick();
    d_access("ld20b", 16'h0020, 16'h0000, 1'b1, v);
    chk("ld20b_dout", {16'd0, v}, 32'h4321);

    // Reset during BUSY of a store: no strobe, no write, ports recover
    bus.Data_addr = 16'h0050; bus.Data_din = 16'h7777; bus.Data_rd = 1'b0; bus.D_macc = 1'b1;
    tick(); tick();
    #3 reset = 1'b1; bus.D_macc = 1'b0;
    #1 chk("mrst_cd",   {31'd0, bus.complete_data}, 32'd0);
       chk("mrst_dout", {16'd0, bus.Data_dout}, 32'h0);
    tick(); reset = 1'b0; tick();
    chk("mrst_cd2", {31'd0, bus.complete_data}, 32'd0);
    d_access("ld50", 16'h0050, 16'h0000, 1'b1, v);
    chk("ld50_dout", {16'd0, v}, 32'h2222);
    i_fetch("f10", 16'h0010, v);
    chk("f10_dout", {16'd0, v}, 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
